imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory read port. Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into instruction memory at word-aligned byte addresses.
- Holds the CPU core stalled via cpu_hold while a load is in progress.
- Sits between the host/UART byte receiver and the write port of Ins_Mem.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts the byte this cycle; transfer occurs when in_valid && in_ready.
- mem_we  output  1  one-cycle instruction memory write strobe.
- mem_addr  output  32  byte address for the write; 4-aligned.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  high from start acceptance until DONE; the core PC is held while high.
- busy  output  1  high in any state other than IDLE/DONE.
- done  output  1  sticky; high in DONE, cleared by the next start or by reset.
- err  output  1  sticky error flag, valid while done is high.
- words_written  output  16  count of words committed in the current load.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready, mem_we, cpu_hold, busy, done, err = 0.
  - mem_addr = BASE_ADDR; mem_wdata = 0; words_written = 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N data bytes. Byte 0 of each group goes to bits [7:0].
- State machine:
  - IDLE/DONE: on start, go to LEN_LO. Set cpu_hold=1, clear done, err, words_written; mem_addr=BASE_ADDR.
  - LEN_LO: in_ready=1; on a transfer, latch the low byte and go to LEN_HI.
  - LEN_HI: in_ready=1; on a transfer, form N.
    - N==0: go to DONE, err=0.
    - N>DEPTH_WORDS: go to DONE, err=1, no writes.
    - Otherwise: go to DATA with byte index 0.
  - DATA: in_ready=1. Each transfer shifts the byte into the word at position byte_idx (0..3). On the transfer with byte_idx==3, go to WRITE.
  - WRITE: in_ready=0 for exactly one cycle; mem_we=1 with the current mem_addr and mem_wdata.
    - The next cycle mem_addr += 4 and words_written += 1.
    - If words_written reaches N, go to DONE; else return to DATA.
  - DONE: cpu_hold=0, busy=0, done=1.
- Throughput: 1 byte per cycle while in_valid is held. Each word costs 5 cycles (4 bytes + 1 write cycle).
- Backpressure: cycles with in_valid=0 stall the state with no effect. Bytes are never dropped or duplicated.
- Start while busy: ignored.
- Reset mid-load: returns to IDLE on the next edge. Partial words are discarded; no write strobe follows; cpu_hold drops.
- Addressing: mem_addr wraps modulo 2^32, never reached in range-checked loads since N<=DEPTH_WORDS.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHK accepts one extra byte.
  - Expected value is the XOR of every byte received after LEN_HI (length bytes excluded).
  - A mismatch sets err=1; either way the block then goes to DONE. Writes already performed are not undone.
  - For N==0, CHK still expects one byte, with value 0x00.
- Not defined: no CHK state; the stream ends after the last data byte.

Test Plan:
- Bytes 02 00 13 00 00 00 93 00 10 00, in_valid held -> two mem_we pulses: addr 0x0 data 0x00000013, addr 0x4 data 0x00100093. done=1, err=0, words_written=2, cpu_hold low after DONE.
- Same stream with in_valid=0 inserted every other cycle -> identical writes. in_ready never asserts during WRITE.
- LEN = 0x0101 (257) with DEPTH_WORDS=256 -> no mem_we, done=1, err=1.
- LEN = 0 -> DONE two transfers after start, err=0, zero writes (with CHECKSUM_EN: a trailing 0x00 is required and gives err=0).
- Reset asserted after 6 data bytes -> IDLE, no mem_we beyond the first word. A fresh start reloads from BASE_ADDR.
- CHECKSUM_EN, one word 13 00 00 00 with checksum 0x12 -> word written, err=1. Checksum 0x13 -> err=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction memory write port
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte stream to little-endian 32-bit instruction memory writes; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module imem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE} state_t;
  state_t state, state_n;
  logic [7:0] len_lo;
  logic [15:0] len, len_n;
  logic [1:0] byte_idx;
  logic [31:0] addr, wdata;
  logic xfer, over, last, idle;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] cks;
`else
  localparam state_t FIN = DONE;
`endif
  assign len_n = {bus.in_data, len_lo};
  assign over = {16'd0, len_n} > 32'(DEPTH_WORDS);
  assign last = words_written + 16'd1 == len;
  assign idle = state inside {IDLE, DONE};
  assign bus.in_ready = state inside {LEN_LO, LEN_HI, DATA, CHK};
  assign xfer = bus.in_valid && bus.in_ready;
  assign bus.mem_we = state == WRITE;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
  assign busy = !idle;
  assign cpu_hold = busy;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next state: one byte per transfer, one write cycle per assembled word
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? LEN_LO : state;
      LEN_LO:     state_n = xfer ? LEN_HI : state;
      LEN_HI:     state_n = !xfer ? state : len_n == 16'd0 ? FIN : over ? DONE : DATA;
      DATA:       state_n = xfer && byte_idx == 2'd3 ? WRITE : state;
      WRITE:      state_n = last ? FIN : DATA;
      CHK:        state_n = xfer ? DONE : state;
      default:    state_n = IDLE;
    endcase
  end
  // length capture, word assembly, address and count bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= BASE_ADDR;
      wdata <= '0;
      words_written <= '0;
      err <= 1'b0;
      len_lo <= '0;
      len <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          addr <= BASE_ADDR;
          words_written <= '0;
          err <= 1'b0;
          byte_idx <= '0;
        end
        LEN_LO: if (xfer) len_lo <= bus.in_data;
        LEN_HI: if (xfer) begin
          len <= len_n;
          err <= over;
          byte_idx <= '0;
        end
        DATA: if (xfer) begin
          wdata[{byte_idx, 3'b000} +: 8] <= bus.in_data;
          byte_idx <= byte_idx + 2'd1;
        end
        WRITE: begin
          addr <= addr + 32'd4;
          words_written <= words_written + 16'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: if (xfer) err <= bus.in_data != cks;
`endif
        default: ;
      endcase
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  // running XOR of every data byte, restarted on each accepted start
  always_ff @(posedge clk)
    if (reset || (idle && start)) cks <= '0;
    else if (state == DATA && xfer) cks <= cks ^ bus.in_data;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven, hand-written and randomized checks of imem_loader against a stream-level model
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    string       nm;
    logic [15:0] n;
    logic [63:0] b;
    int          gap;
    int          nw;
    logic [31:0] w0, w1;
    logic        e;
  } vec_t;

  logic clk = 0, reset = 1, start = 0;
  logic cpu_hold, busy, done, err;
  logic [15:0] words_written;
  int errors = 0, checks = 0, viol = 0;
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  logic exp_e;
  bq_t s, data;
  vec_t tbl[6];

  imem_loader_if bus();

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      got_a.push_back(bus.mem_addr);
      got_d.push_back(bus.mem_wdata);
    end
    if (bus.mem_we && bus.in_ready) viol++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1;
    bus.in_data = b;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready=0 required 1");
    end
    @(negedge clk);
    bus.in_valid = 0;
  endtask

  function automatic bq_t mk_stream(input logic [15:0] n, input bq_t d, input logic [7:0] flip);
    bq_t r;
    logic [7:0] x = 8'h00;
    r.push_back(n[7:0]);
    r.push_back(n[15:8]);
    if (32'(n) <= 32'(DEPTH)) begin
      foreach (d[i]) begin
        r.push_back(d[i]);
        x = x ^ d[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      r.push_back(x ^ flip);
`else
      x = x ^ flip;
`endif
    end
    return r;
  endfunction

  // Reference: interpret a stream as the host would describe it.
  task automatic model(input bq_t st);
    int n;
    logic [7:0] x = 8'h00;
    n = int'({st[1], st[0]});
    exp_a = {};
    exp_d = {};
    exp_e = 1'b1;
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(BASE + 32'(4 * i));
      exp_d.push_back({st[2+4*i+3], st[2+4*i+2], st[2+4*i+1], st[2+4*i]});
      for (int j = 0; j < 4; j++) x = x ^ st[2+4*i+j];
    end
    exp_e = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_e = st[2+4*n] != x;
`endif
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic drive_load(input bq_t st, input int gap);
    got_a = {};
    got_d = {};
    viol = 0;
    pulse_start();
    chk("hold_on_start", 32'(cpu_hold), 1);
    chk("busy_on_start", 32'(busy), 1);
    chk("done_cleared", 32'(done), 0);
    foreach (st[i]) send_byte(st[i], gap < 0 ? int'($urandom_range(0, 2)) : gap);
    wait_done();
  endtask

  task automatic check_final(input string nm);
    chk({nm, ".done"}, 32'(done), 1);
    chk({nm, ".err"}, 32'(err), 32'(exp_e));
    chk({nm, ".words"}, 32'(words_written), 32'(exp_a.size()));
    chk({nm, ".hold"}, 32'(cpu_hold), 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".addr_end"}, bus.mem_addr, BASE + 32'(4 * exp_a.size()));
    chk({nm, ".nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("%s.wa%0d", nm, i), got_a[i], exp_a[i]);
      chk($sformatf("%s.wd%0d", nm, i), got_d[i], exp_d[i]);
    end
    chk({nm, ".ready_in_write"}, 32'(viol), 0);
  endtask

  initial begin
    tbl[0] = '{"plan", 16'd2, 64'h13000000_93001000, 0, 2, 32'h00000013, 32'h00100093, 1'b0};
    tbl[1] = '{"plan_gap", 16'd2, 64'h13000000_93001000, 1, 2, 32'h00000013, 32'h00100093, 1'b0};
    tbl[2] = '{"len257", 16'h0101, 64'h0, 0, 0, 32'h0, 32'h0, 1'b1};
    tbl[3] = '{"len0", 16'd0, 64'h0, 0, 0, 32'h0, 32'h0, 1'b0};
    tbl[4] = '{"one_word", 16'd1, 64'hefbeadde_00000000, 0, 1, 32'hdeadbeef, 32'h0, 1'b0};
    tbl[5] = '{"rand_gap", 16'd2, 64'h01020304_05060708, -1, 2, 32'h04030201, 32'h08070605, 1'b0};
    bus.in_valid = 0;
    bus.in_data = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 32'(bus.in_ready), 0);
    chk("rst.mem_we", 32'(bus.mem_we), 0);
    chk("rst.cpu_hold", 32'(cpu_hold), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.mem_addr", bus.mem_addr, BASE);
    chk("rst.mem_wdata", bus.mem_wdata, 0);
    chk("rst.words", 32'(words_written), 0);
    reset = 0;
    bus.in_valid = 1;
    repeat (2) @(negedge clk);
    chk("idle.no_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 0;

    foreach (tbl[k]) begin
      data = {};
      for (int i = 0; i < 4 * tbl[k].nw; i++) data.push_back(tbl[k].b[63-8*i -: 8]);
      s = mk_stream(tbl[k].n, data, 8'h00);
      exp_a = {};
      exp_d = {};
      if (tbl[k].nw > 0) begin exp_a.push_back(BASE); exp_d.push_back(tbl[k].w0); end
      if (tbl[k].nw > 1) begin exp_a.push_back(BASE + 32'd4); exp_d.push_back(tbl[k].w1); end
      exp_e = tbl[k].e;
      drive_load(s, tbl[k].gap);
      check_final(tbl[k].nm);
    end

    // zero-length load completes on the second transfer
    got_a = {};
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("len0.await_chk", 32'(busy), 1);
    send_byte(8'h00, 0);
`endif
    chk("len0.done_now", 32'(done), 1);
    chk("len0.err", 32'(err), 0);

    // reset after six data bytes discards the partial word
    got_a = {};
    got_d = {};
    pulse_start();
    foreach (tbl[0].b[i]) if (i < 1) ;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.hold", 32'(cpu_hold), 0);
    chk("midrst.ready", 32'(bus.in_ready), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.words", 32'(words_written), 0);
    chk("midrst.addr", bus.mem_addr, BASE);
    repeat (5) @(negedge clk);
    chk("midrst.nwrites", 32'(got_a.size()), 1);
    if (got_a.size() > 0) chk("midrst.wd0", got_d[0], 32'h00000013);
    data = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    s = mk_stream(16'd2, data, 8'h00);
    model(s);
    drive_load(s, 0);
    check_final("reload");

    // a start pulse in the middle of a load is ignored
    got_a = {};
    got_d = {};
    viol = 0;
    data = {8'hef, 8'hbe, 8'had, 8'hde};
    s = mk_stream(16'd1, data, 8'h00);
    model(s);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(s[i], 0);
    pulse_start();
    for (int i = 4; i < s.size(); i++) send_byte(s[i], 0);
    wait_done();
    check_final("start_busy");

`ifdef IMEM_LOADER_CHECKSUM_EN
    data = {8'h13, 8'h00, 8'h00, 8'h00};
    s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    model(s);
    drive_load(s, 0);
    check_final("cks_bad");
    s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    model(s);
    drive_load(s, 0);
    check_final("cks_good");
`endif

    // full-depth load is accepted
    data = {};
    for (int i = 0; i < 4 * DEPTH; i++) data.push_back(8'($urandom_range(0, 255)));
    s = mk_stream(16'(DEPTH), data, 8'h00);
    model(s);
    drive_load(s, 0);
    check_final("full_depth");

    for (int r = 0; r < 25; r++) begin
      logic [15:0] n;
      n = $urandom_range(0, 7) == 0 ? 16'($urandom_range(DEPTH + 1, 65535)) : 16'($urandom_range(0, 5));
      data = {};
      for (int i = 0; i < 4 * int'(n) && n <= 16'(DEPTH); i++) data.push_back(8'($urandom_range(0, 255)));
      s = mk_stream(n, data, $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 255)) : 8'h00);
      model(s);
      drive_load(s, -1);
      check_final($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
